ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter DATA_LEN, default 16, word width per lane.
REQ-002 SHALL have parameter ADDRESS_LEN, default 8, address width per lane.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0, req1  input  1 each  access request from requester 0 / 1.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; qualified by reqN.
REQ-007 addr0, addr1  input  3*ADDRESS_LEN each  three packed lane addresses, lane 0 in LSBs.
REQ-008 wdata0, wdata1  input  3*DATA_LEN each  three packed write words, lane 0 in LSBs.
REQ-009 gnt0, gnt1  output  1 each  one-cycle pulse; request accepted.
REQ-010 rvalid0, rvalid1  output  1 each  one-cycle pulse; rdata holds that requester's read result.
REQ-011 rdata  output  3*DATA_LEN  registered read result, shared by both requesters.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 ram_read, ram_write  output  1 each  strobes to the triple-lane RAM.
REQ-014 ram_address  output  3*ADDRESS_LEN  registered RAM address bus.
REQ-015 ram_data_in  output  3*DATA_LEN  registered RAM write data.
REQ-016 ram_data_out  input  3*DATA_LEN  RAM read data, valid the cycle after the read strobe edge.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE, no reqN high: remain IDLE; ram strobes 0.
REQ-019 IDLE, any reqN high: select winner, register its addr/wdata/we into ram_address/ram_data_in, record owner, go to ISSUE.
REQ-020 Arbitration SHALL be round-robin: single request wins; when both are high, the requester not granted last wins; the last-grant pointer updates on every grant.
REQ-021 ISSUE: assert gnt of owner for exactly this cycle; assert ram_write if owner we = 1, else ram_read; never both.
REQ-022 ISSUE, write: next state IDLE; the RAM commits all three lanes at the end of ISSUE; no rvalid is produced.
REQ-023 ISSUE, read: next state WAIT.
REQ-024 WAIT: strobes 0; capture ram_data_out into rdata at the end of the cycle; next state DONE.
REQ-025 DONE: assert rvalid of owner for one cycle; rdata stable; next state IDLE.
REQ-026 Latency: a read request sampled in IDLE in cycle T gives gnt in T+1 and rvalid in T+3. A write request sampled in T gives gnt and ram_write in T+1. Back-to-back accesses need at least 2 cycles per write and 4 cycles per read.
REQ-027 Requesters SHALL hold reqN, weN, addrN and wdataN until gnt; reqN still high in the IDLE after completion is a new request.
REQ-028 Inputs are ignored outside IDLE; a request arriving mid-transaction waits; none is dropped or queued beyond the held level.
REQ-029 rdata SHALL retain its last captured value until the next WAIT capture.
REQ-030 Lane-address collisions inside one access are passed unchanged to the RAM; the arbiter does not check them.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE; gnt0/1, rvalid0/1, ram_read, ram_write, busy = 0; ram_address, ram_data_in, rdata = 0; last-grant pointer = 1, so requester 0 wins the first contention.
REQ-032 Reset asserted mid-transaction SHALL abandon the access: no gnt, rvalid or strobe pulse follows reset release; operation resumes from IDLE.

Verification
REQ-033 Single read: req0 = 1, we0 = 0, addr0 = {8'd2, 8'd1, 8'd0}, RAM words 6, 8, 4 -> gnt0 at T+1, ram_read at T+1, rvalid0 at T+3 with rdata = {6, 8, 4}.
REQ-034 Single write: req1 = 1, we1 = 1, addr1 = {8'd62, 8'd61, 8'd60}, wdata1 = {16'd3, 16'd2, 16'd1} -> gnt1 and ram_write at T+1, no rvalid; a later read of the same addresses returns {3, 2, 1}.
REQ-035 Contention after reset: req0 = req1 = 1, both held -> grants alternate 0, 1, 0, 1; no gnt is issued while busy = 1.
REQ-036 Reset mid-read: rst_n low during WAIT -> all outputs 0 at once, no rvalid after release, and the next req1 is served normally.
REQ-037 Late request: req1 is raised during ISSUE of a req0 read -> req1 is granted only in the ISSUE that follows DONE.
REQ-038 Strobe exclusivity: over random traffic, ram_read and ram_write are never high together, and each is high for exactly one cycle per grant.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a triple-lane RAM.
// Each access moves all three lanes; reads return through one shared registered rdata bus.
module ram_arbiter #(
   parameter int unsigned DATA_LEN    = 16,
   parameter int unsigned ADDRESS_LEN = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req0,
   input  logic                       req1,
   input  logic                       we0,
   input  logic                       we1,
   input  logic [3*ADDRESS_LEN-1:0]   addr0,
   input  logic [3*ADDRESS_LEN-1:0]   addr1,
   input  logic [3*DATA_LEN-1:0]      wdata0,
   input  logic [3*DATA_LEN-1:0]      wdata1,
   output logic                       gnt0,
   output logic                       gnt1,
   output logic                       rvalid0,
   output logic                       rvalid1,
   output logic [3*DATA_LEN-1:0]      rdata,
   output logic                       busy,
   output logic                       ram_read,
   output logic                       ram_write,
   output logic [3*ADDRESS_LEN-1:0]   ram_address,
   output logic [3*DATA_LEN-1:0]      ram_data_in,
   input  logic [3*DATA_LEN-1:0]      ram_data_out
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   state_e                     state_q, state_d;
   logic                       owner_q, owner_d;
   logic                       we_q, we_d;
   logic                       last_q, last_d;
   logic                       winner;
   logic [3*ADDRESS_LEN-1:0]   ram_address_q, ram_address_d;
   logic [3*DATA_LEN-1:0]      ram_data_in_q, ram_data_in_d;
   logic [3*DATA_LEN-1:0]      rdata_q, rdata_d;

   // last_q resets to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         owner_q       <= 1'b0;
         we_q          <= 1'b0;
         last_q        <= 1'b1;
         ram_address_q <= '0;
         ram_data_in_q <= '0;
         rdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         we_q          <= we_d;
         last_q        <= last_d;
         ram_address_q <= ram_address_d;
         ram_data_in_q <= ram_data_in_d;
         rdata_q       <= rdata_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      we_d          = we_q;
      last_d        = last_q;
      ram_address_d = ram_address_q;
      ram_data_in_d = ram_data_in_q;
      rdata_d       = rdata_q;
      winner        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               winner        = (req0 && req1) ? ~last_q : req1;
               owner_d       = winner;
               last_d        = winner;
               we_d          = winner ? we1 : we0;
               ram_address_d = winner ? addr1 : addr0;
               ram_data_in_d = winner ? wdata1 : wdata0;
               state_d       = StIssue;
            end
         end
         StIssue: state_d = we_q ? StIdle : StWait;
         StWait: begin
            rdata_d = ram_data_out;
            state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      gnt0        = (state_q == StIssue) && !owner_q;
      gnt1        = (state_q == StIssue) && owner_q;
      ram_write   = (state_q == StIssue) && we_q;
      ram_read    = (state_q == StIssue) && !we_q;
      rvalid0     = (state_q == StDone) && !owner_q;
      rvalid1     = (state_q == StDone) && owner_q;
      busy        = (state_q != StIdle);
      rdata       = rdata_q;
      ram_address = ram_address_q;
      ram_data_in = ram_data_in_q;
   end

endmodule
